// File: rtl/mem_bus_pkg.sv
// Shared types and constant helpers for the memory pin-bus serializer.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    WR   = 3'd2,
    WAIT = 3'd3,
    RD   = 3'd4,
    RSP  = 3'd5
  } state_t;

  // Number of den-wide beats needed to carry num bits.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mem_bus_serializer_if.sv
// CPU request/response and external pin-bus signals of the serializer.
// Parity pins exist only when MEM_BUS_PARITY_EN is defined.
interface mem_bus_serializer_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PIN_W  = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [PIN_W-1:0]  pin_out;
  logic              pin_oe;
  logic              pin_frame;
  logic [PIN_W-1:0]  pin_in;
`ifdef MEM_BUS_PARITY_EN
  logic              pin_par_out;
  logic              pin_par_in;
  logic              rsp_err;
`endif

  // Environment side: CPU plus the external memory device.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, pin_in,
`ifdef MEM_BUS_PARITY_EN
    output pin_par_in,
    input  pin_par_out, rsp_err,
`endif
    input  req_ready, rsp_valid, rsp_rdata, pin_out, pin_oe, pin_frame
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, pin_in,
`ifdef MEM_BUS_PARITY_EN
    input  pin_par_in,
    output pin_par_out, rsp_err,
`endif
    output req_ready, rsp_valid, rsp_rdata, pin_out, pin_oe, pin_frame
  );

endinterface

// File: rtl/mem_bus_shift_reg.sv
// Parallel-load shift register moving BEAT_W-bit beats toward the MSB end.
module mem_bus_shift_reg #(
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned NBEATS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [BEAT_W*NBEATS-1:0] load_val,
  input  logic                     shift,
  input  logic [BEAT_W-1:0]        shift_in,
  output logic [BEAT_W*NBEATS-1:0] q
);

  localparam int unsigned W = BEAT_W * NBEATS;

  // Load has priority over shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= W'({q, shift_in});
    end
  end

endmodule

// File: rtl/mem_bus_serializer.sv
// Serializes CPU read/write requests onto a narrow pin bus: header, write data
// or wait + read data. Optional parity pins enabled by MEM_BUS_PARITY_EN.
module mem_bus_serializer
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PIN_W       = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                reset,
  mem_bus_serializer_if.slave bus
);

  localparam int unsigned NA        = ceil_div(ADDR_W + 1, PIN_W);
  localparam int unsigned ND        = ceil_div(DATA_W, PIN_W);
  localparam int unsigned NB        = (NA > ND) ? NA : ND;
  localparam int unsigned SR_W      = NB * PIN_W;
  localparam int unsigned HDR_W     = NA * PIN_W;
  localparam int unsigned DAT_W     = ND * PIN_W;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned WAIT_LAST = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [PIN_W-1:0]  pin_out_q, pin_out_d;
  logic              pin_oe_q, pin_oe_d;
  logic              pin_frame_q, pin_frame_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              sr_load, sr_shift;
  logic [SR_W-1:0]   sr_load_val, sr_q;
  logic [SR_W-1:0]   hdr_aligned, dat_aligned;
  logic [PIN_W-1:0]  sr_top;

`ifdef MEM_BUS_PARITY_EN
  logic err_acc_q, err_acc_d;
  logic rsp_err_q, rsp_err_d;
  logic par_out_q;
  logic beat_err;
`endif

  mem_bus_shift_reg #(
    .BEAT_W (PIN_W),
    .NBEATS (NB)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (sr_load),
    .load_val (sr_load_val),
    .shift    (sr_shift),
    .shift_in (bus.pin_in),
    .q        (sr_q)
  );

  // Header and write data are left-aligned so the first beat sits at the top.
  assign hdr_aligned = SR_W'({bus.req_write, bus.req_addr}) << (SR_W - HDR_W);
  assign dat_aligned = SR_W'(wdata_q) << (SR_W - DAT_W);
  assign sr_top      = sr_q[SR_W-1 -: PIN_W];

`ifdef MEM_BUS_PARITY_EN
  assign beat_err = (^bus.pin_in) ^ bus.pin_par_in;
`endif

  // Next state and next registered outputs; pin_out_d is the beat for the next cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    pin_out_d   = '0;
    pin_oe_d    = 1'b0;
    pin_frame_d = 1'b0;
    rsp_valid_d = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_load_val = hdr_aligned << PIN_W;
`ifdef MEM_BUS_PARITY_EN
    err_acc_d   = err_acc_q;
    rsp_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d     = HDR;
          cnt_d       = '0;
          wr_d        = bus.req_write;
          wdata_d     = bus.req_wdata;
          sr_load     = 1'b1;
          sr_load_val = hdr_aligned << PIN_W;
          pin_out_d   = hdr_aligned[SR_W-1 -: PIN_W];
          pin_oe_d    = 1'b1;
          pin_frame_d = 1'b1;
`ifdef MEM_BUS_PARITY_EN
          err_acc_d   = 1'b0;
`endif
        end
      end
      HDR: begin
        if (cnt_q == CNT_W'(NA - 1)) begin
          cnt_d = '0;
          if (wr_q) begin
            state_d     = WR;
            sr_load     = 1'b1;
            sr_load_val = dat_aligned << PIN_W;
            pin_out_d   = dat_aligned[SR_W-1 -: PIN_W];
            pin_oe_d    = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d = RD;
          end else begin
            state_d = WAIT;
          end
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          sr_shift  = 1'b1;
          pin_out_d = sr_top;
          pin_oe_d  = 1'b1;
        end
      end
      WR: begin
        if (cnt_q == CNT_W'(ND - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          sr_shift  = 1'b1;
          pin_out_d = sr_top;
          pin_oe_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(WAIT_LAST)) begin
          state_d = RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD: begin
        sr_shift = 1'b1;
`ifdef MEM_BUS_PARITY_EN
        err_acc_d = err_acc_q | beat_err;
`endif
        if (cnt_q == CNT_W'(ND - 1)) begin
          state_d     = RSP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rdata_d     = DATA_W'({sr_q, bus.pin_in});
`ifdef MEM_BUS_PARITY_EN
          rsp_err_d   = err_acc_q | beat_err;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      pin_out_q   <= '0;
      pin_oe_q    <= 1'b0;
      pin_frame_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
`ifdef MEM_BUS_PARITY_EN
      err_acc_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      par_out_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      pin_out_q   <= pin_out_d;
      pin_oe_q    <= pin_oe_d;
      pin_frame_q <= pin_frame_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef MEM_BUS_PARITY_EN
      err_acc_q   <= err_acc_d;
      rsp_err_q   <= rsp_err_d;
      par_out_q   <= pin_oe_d & (^pin_out_d);
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.pin_out   = pin_out_q;
  assign bus.pin_oe    = pin_oe_q;
  assign bus.pin_frame = pin_frame_q;
`ifdef MEM_BUS_PARITY_EN
  assign bus.pin_par_out = par_out_q;
  assign bus.rsp_err     = rsp_err_q;
`endif

endmodule
